// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single ROB writeback path between execution units.
// Each requester owns a small circular FIFO of {tag_PRF, tag_ROB} completions.
// A round-robin scheduler pops at most one entry per cycle onto a registered CDB.
// Honours back-end freeze (hold pops) and flush (drop everything queued).
module cdb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 2,
  parameter int PRF_W   = 5,
  parameter int ROB_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze_back,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         valid_in,
  input  logic [NUM_REQ*PRF_W-1:0]   tag_PRF_in,
  input  logic [NUM_REQ*ROB_W-1:0]   tag_ROB_in,
  output logic [NUM_REQ-1:0]         ready_out,
  output logic                       valid_cdb,
  output logic [PRF_W-1:0]           tag_PRF_cdb,
  output logic [ROB_W-1:0]           tag_ROB_cdb,
  output logic [$clog2(NUM_REQ)-1:0] grant_cdb,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // FIFO bookkeeping and storage
  logic [PW-1:0]    wr_ptr_q [NUM_REQ];
  logic [PW-1:0]    wr_ptr_d [NUM_REQ];
  logic [PW-1:0]    rd_ptr_q [NUM_REQ];
  logic [PW-1:0]    rd_ptr_d [NUM_REQ];
  logic [CW-1:0]    count_q  [NUM_REQ];
  logic [CW-1:0]    count_d  [NUM_REQ];
  logic [PRF_W-1:0] prf_mem_q [NUM_REQ][DEPTH];
  logic [ROB_W-1:0] rob_mem_q [NUM_REQ][DEPTH];

  // Scheduler state and per-cycle decisions
  logic [GW-1:0]      rr_q;
  logic [GW-1:0]      rr_d;
  logic [NUM_REQ-1:0] nonempty_s;
  logic [NUM_REQ-1:0] push_s;
  logic               pop_s;
  logic [GW-1:0]      win_s;

  // CDB output register
  logic             valid_q, valid_d;
  logic [PRF_W-1:0] prf_q, prf_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [GW-1:0]    grant_q, grant_d;

  // Status from registered counts only: a same-cycle pop never raises ready.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty_s[i] = (count_q[i] != '0);
      ready_out[i]  = (count_q[i] != CW'(DEPTH));
      busy          = busy | nonempty_s[i];
    end
  end

  // Round-robin pick: first non-empty FIFO scanning from rr_q with wrap.
  always_comb begin
    logic [GW:0] idx;
    pop_s = 1'b0;
    win_s = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (GW+1)'(k);
      idx = (idx >= (GW+1)'(NUM_REQ)) ? idx - (GW+1)'(NUM_REQ) : idx;
      if (!pop_s && nonempty_s[idx[GW-1:0]]) begin
        pop_s = 1'b1;
        win_s = idx[GW-1:0];
      end else begin
        pop_s = pop_s;
      end
    end
    if (freeze_back || flush) begin
      pop_s = 1'b0;
    end else begin
      pop_s = pop_s;
    end
  end

  // Pointer advance: after a winner, or hold when nothing was popped.
  always_comb begin
    if (flush) begin
      rr_d = '0;
    end else if (pop_s) begin
      rr_d = (win_s == GW'(NUM_REQ - 1)) ? '0 : win_s + GW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Per-FIFO next state; a popped slot is read from pre-edge state, so no bypass.
  always_comb begin
    logic pop_i;
    pop_i = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      push_s[i] = valid_in[i] && (count_q[i] != CW'(DEPTH)) && !flush;
      pop_i     = pop_s && (win_s == GW'(i));
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        wr_ptr_d[i] = push_s[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
        rd_ptr_d[i] = pop_i ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
        count_d[i]  = count_q[i] + CW'(push_s[i]) - CW'(pop_i);
      end
    end
  end

  // CDB next value: load the popped entry, otherwise idle with tags held.
  always_comb begin
    if (pop_s) begin
      valid_d = 1'b1;
      prf_d   = prf_mem_q[win_s][rd_ptr_q[win_s]];
      rob_d   = rob_mem_q[win_s][rd_ptr_q[win_s]];
      grant_d = win_s;
    end else begin
      valid_d = 1'b0;
      prf_d   = prf_q;
      rob_d   = rob_q;
      grant_d = grant_q;
    end
  end

  // FIFO control and scheduler pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_q <= rr_d;
    end
  end

  // FIFO payload storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) begin
        prf_mem_q[i][wr_ptr_q[i]] <= tag_PRF_in[i*PRF_W +: PRF_W];
        rob_mem_q[i][wr_ptr_q[i]] <= tag_ROB_in[i*ROB_W +: ROB_W];
      end
    end
  end

  // Registered CDB broadcast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      prf_q   <= '0;
      rob_q   <= '0;
      grant_q <= '0;
    end else begin
      valid_q <= valid_d;
      prf_q   <= prf_d;
      rob_q   <= rob_d;
      grant_q <= grant_d;
    end
  end

  assign valid_cdb   = valid_q;
  assign tag_PRF_cdb = prf_q;
  assign tag_ROB_cdb = rob_q;
  assign grant_cdb   = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model of the arbiter.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 2;
  localparam int PRF_W   = 5;
  localparam int ROB_W   = 4;
  localparam int LSZ     = 4096;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     freeze_back;
  logic                     flush;
  logic [NUM_REQ-1:0]       valid_in;
  logic [NUM_REQ*PRF_W-1:0] tag_PRF_in;
  logic [NUM_REQ*ROB_W-1:0] tag_ROB_in;
  logic [NUM_REQ-1:0]       ready_out;
  logic                     valid_cdb;
  logic [PRF_W-1:0]         tag_PRF_cdb;
  logic [ROB_W-1:0]         tag_ROB_cdb;
  logic [0:0]               grant_cdb;
  logic                     busy;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .PRF_W(PRF_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .freeze_back(freeze_back), .flush(flush),
    .valid_in(valid_in), .tag_PRF_in(tag_PRF_in), .tag_ROB_in(tag_ROB_in),
    .ready_out(ready_out), .valid_cdb(valid_cdb), .tag_PRF_cdb(tag_PRF_cdb),
    .tag_ROB_cdb(tag_ROB_cdb), .grant_cdb(grant_cdb), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one unbounded list per requester (head/tail indices),
  // a round-robin start index, and the expected CDB contents.
  logic [PRF_W+ROB_W-1:0] mlist [NUM_REQ][LSZ];
  int mhead [NUM_REQ];
  int mtail [NUM_REQ];
  int m_rr;
  logic             e_valid;
  logic [PRF_W-1:0] e_prf;
  logic [ROB_W-1:0] e_rob;
  int               e_grant;

  // Requester-side drive state
  logic [NUM_REQ-1:0] pv;
  logic [PRF_W-1:0]   pprf [NUM_REQ];
  logic [ROB_W-1:0]   prob [NUM_REQ];
  logic [NUM_REQ-1:0] acc_m;

  function automatic int msize(input int i);
    return mtail[i] - mhead[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) mhead[i] = mtail[i];
    m_rr = 0; e_valid = 1'b0; e_prf = '0; e_rob = '0; e_grant = 0;
  endtask

  task automatic apply();
    valid_in = pv;
    tag_PRF_in = {pprf[1], pprf[0]};
    tag_ROB_in = {prob[1], prob[0]};
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, valid_cdb, 0);
    chk({tag, "_prf"}, tag_PRF_cdb, 0);
    chk({tag, "_rob"}, tag_ROB_cdb, 0);
    chk({tag, "_grant"}, grant_cdb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, ready_out, 2'b11);
  endtask

  // One clock: predict from pre-edge inputs/model, advance, compare at edge+1.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    bit pop;
    int win, idx;
    logic fl;
    logic [PRF_W+ROB_W-1:0] din [NUM_REQ];
    bit bsy;
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("ready%0d", i), ready_out[i], msize(i) != DEPTH);
    fl = flush; acc = '0; pop = 0; win = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      din[i] = {tag_PRF_in[i*PRF_W +: PRF_W], tag_ROB_in[i*ROB_W +: ROB_W]};
      if (!fl) acc[i] = valid_in[i] && (msize(i) < DEPTH);
    end
    if (!fl && !freeze_back) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_rr + k) % NUM_REQ;
        if (!pop && msize(idx) > 0) begin pop = 1; win = idx; end
      end
    end
    @(posedge clk); #1;
    if (fl) begin
      for (int i = 0; i < NUM_REQ; i++) mhead[i] = mtail[i];
      m_rr = 0; e_valid = 1'b0;
    end else begin
      if (pop) begin
        e_valid = 1'b1;
        {e_prf, e_rob} = mlist[win][mhead[win] % LSZ];
        mhead[win]++;
        e_grant = win;
        m_rr = (win + 1) % NUM_REQ;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          mlist[i][mtail[i] % LSZ] = din[i];
          mtail[i]++;
        end
      end
    end
    acc_m = acc;
    bsy = 0;
    for (int i = 0; i < NUM_REQ; i++) if (msize(i) > 0) bsy = 1;
    chk("valid_cdb", valid_cdb, e_valid);
    chk("busy", busy, bsy);
    if (e_valid) begin
      chk("tag_PRF_cdb", tag_PRF_cdb, e_prf);
      chk("tag_ROB_cdb", tag_ROB_cdb, e_rob);
      chk("grant_cdb", grant_cdb, e_grant);
    end
  endtask

  initial begin
    int ctr0, ctr1, p;
    logic fl_prev;
    rst = 1'b1; freeze_back = 1'b0; flush = 1'b0;
    pv = '0; acc_m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pprf[i] = '0; prob[i] = '0; mhead[i] = 0; mtail[i] = 0;
    end
    model_reset();
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Single add completion: accept at edge 1, on CDB after edge 2.
    pv = 2'b01; pprf[0] = 5'd7; prob[0] = 4'd3; apply();
    step();
    pv = 2'b00; apply();
    step();
    chk("single_valid", valid_cdb, 1);
    chk("single_prf", tag_PRF_cdb, 7);
    chk("single_rob", tag_ROB_cdb, 3);
    chk("single_grant", grant_cdb, 0);
    step();
    chk("single_busy", busy, 0);

    // Flush an idle arbiter so the round-robin start is back at requester 0.
    flush = 1'b1; step(); flush = 1'b0;

    // Full contention: alternating grants starting at 0, mul backpressured.
    ctr0 = 1; ctr1 = 9; p = 0; pv = 2'b11;
    for (int c = 0; c < 12; c++) begin
      pprf[0] = 5'(ctr0); prob[0] = 4'(ctr0);
      pprf[1] = 5'(ctr1 + 16); prob[1] = 4'(ctr1);
      apply();
      step();
      if (acc_m[0]) ctr0++;
      if (acc_m[1]) ctr1++;
      if (c > 0) begin
        chk("cont_valid", valid_cdb, 1);
        chk("cont_grant", grant_cdb, p % 2);
        p++;
      end
    end

    // Flush with both FIFOs loaded and new beats offered.
    pv = 2'b11; apply();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", valid_cdb, 0);
    chk("flush_ready", ready_out, 2'b11);
    pv = 2'b00; apply();
    repeat (3) step();

    // Freeze: queue one entry each, hold 3 cycles, then add before mul.
    pv = 2'b11; pprf[0] = 5'd5; prob[0] = 4'd4; pprf[1] = 5'd6; prob[1] = 4'd8;
    freeze_back = 1'b1; apply();
    step();
    pv = 2'b00; apply();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("frz_busy", busy, 1);
      chk("frz_valid", valid_cdb, 0);
    end
    freeze_back = 1'b0;
    step();
    chk("frz_g0", grant_cdb, 0);
    chk("frz_prf0", tag_PRF_cdb, 5);
    chk("frz_rob0", tag_ROB_cdb, 4);
    step();
    chk("frz_g1", grant_cdb, 1);
    chk("frz_prf1", tag_PRF_cdb, 6);
    chk("frz_rob1", tag_ROB_cdb, 8);
    step();

    // Randomized traffic with occasional freeze and flush; held beats persist.
    fl_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      freeze_back = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] || acc_m[i] || fl_prev) begin
          pv[i] = ($urandom_range(0, 2) != 0);
          pprf[i] = PRF_W'($urandom);
          prob[i] = ROB_W'($urandom);
        end
      end
      apply();
      fl_prev = flush;
      step();
    end
    flush = 1'b0;

    // Async reset mid-stream with entries queued.
    pv = 2'b11; freeze_back = 1'b1; apply();
    step();
    #3;
    rst = 1'b1;
    #1;
    check_reset("arst");
    model_reset();
    pv = 2'b00; freeze_back = 1'b0; apply();
    #2;
    rst = 1'b0;
    pv = 2'b01; pprf[0] = 5'h1a; prob[0] = 4'd5; apply();
    step();
    pv = 2'b00; apply();
    step();
    chk("post_rst_valid", valid_cdb, 1);
    chk("post_rst_prf", tag_PRF_cdb, 5'h1a);
    chk("post_rst_rob", tag_ROB_cdb, 5);
    chk("post_rst_grant", grant_cdb, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
